// File: rtl/merge_out_serializer.sv
// merge_out_serializer: buffers 4-element sorted words with their mode tag in a
// small word FIFO and streams them out one element per beat (element 0 first),
// tagging each beat with its index, first/last markers and mode.
module merge_out_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         s,
  input  logic [4*WIDTH-1:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_idx,
  output logic               out_first,
  output logic               out_last,
  output logic [1:0]         out_mode,
  output logic [AW:0]        fifo_cnt
);

  localparam int        WW      = 4 * WIDTH + 2;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  // Word storage; the head is read combinationally so a pushed word is
  // visible the cycle after its push and the element mux can follow idx.
  logic [WW-1:0]    mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;

  logic             push, accept, pop;
  logic [WW-1:0]    head_word;
  logic [WIDTH-1:0] elem [4];

  assign in_ready  = (cnt_reg < DEPTH_C);
  assign out_valid = (cnt_reg != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign accept    = out_valid & out_ready;
  assign pop       = accept & (idx_reg == 2'd3);

  assign head_word = mem[rd_ptr_reg];

  for (genvar gi = 0; gi < 4; gi++) begin : g_elem
    assign elem[gi] = head_word[gi*WIDTH +: WIDTH];
  end

  // Beat outputs, forced to zero whenever nothing is queued
  always_comb begin
    out_data  = '0;
    out_idx   = 2'd0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_mode  = 2'd0;
    if (out_valid) begin
      out_data  = elem[idx_reg];
      out_idx   = idx_reg;
      out_first = (idx_reg == 2'd0);
      out_last  = (idx_reg == 2'd3);
      out_mode  = head_word[4*WIDTH +: 2];
    end
  end

  assign fifo_cnt = cnt_reg;

  // Next-state for pointers, count and beat index; flush overrides everything
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      cnt_next    = '0;
      idx_next    = 2'd0;
    end else begin
      if (push)
        wr_ptr_next = wr_ptr_reg + 1'b1;
      if (accept)
        idx_next = idx_reg + 2'd1;
      if (pop)
        rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push && !pop)
        cnt_next = cnt_reg + 1'b1;
      else if (pop && !push)
        cnt_next = cnt_reg - 1'b1;
    end
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      idx_reg    <= 2'd0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
    end
  end

  // Word write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {s, y};
  end

endmodule
